// File: rtl/wb_fabric_pkg.sv
// Shared types and helpers for the Wishbone peripheral fabric.
package wb_fabric_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Fault cause codes reported on flt_code
  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_UNMAPPED = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FLT_SLV_ERR  = 2'd3;

  // Bits needed to hold values 0..value-1; never less than 1
  function automatic int clog2(input int value);
    int result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Fault counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/wb_fabric_timer.sv
// Watchdog counter for a slave holding a request; flags the last allowed cycle.
module wb_fabric_timer
  import wb_fabric_pkg::*;
#(
  parameter int  TIMEOUT = 255,
  localparam int TW      = clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] count_q;

  // Count cycles spent waiting on the slave; clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The cycle in which the count reaches TIMEOUT-1 is the slave's last chance
  assign expired = (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_periph_fabric.sv
// Registered single-master, NS-slave Wishbone classic fabric with fault tracking.
module wb_periph_fabric
  import wb_fabric_pkg::*;
#(
  parameter int  NS      = 4,
  parameter int  AW      = 32,
  parameter int  DW      = 128,
  parameter int  MSK     = 24,
  parameter int  TIMEOUT = 255,
  localparam int SW      = DW / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // master side
  input  logic [AW-1:0]    s_wb_adr,
  input  logic [SW-1:0]    s_wb_sel,
  input  logic             s_wb_we,
  input  logic [DW-1:0]    s_wb_dat_i,
  output logic [DW-1:0]    s_wb_dat_o,
  input  logic             s_wb_cyc,
  input  logic             s_wb_stb,
  output logic             s_wb_ack,
  output logic             s_wb_err,
  // slave side
  output logic [NS*AW-1:0] m_wb_adr,
  output logic [NS*SW-1:0] m_wb_sel,
  output logic [NS-1:0]    m_wb_we,
  output logic [NS*DW-1:0] m_wb_dat_o,
  input  logic [NS*DW-1:0] m_wb_dat_i,
  output logic [NS-1:0]    m_wb_cyc,
  output logic [NS-1:0]    m_wb_stb,
  input  logic [NS-1:0]    m_wb_ack,
  input  logic [NS-1:0]    m_wb_err,
  // fault status
  output logic [15:0]      flt_cnt,
  output logic [AW-1:0]    flt_adr,
  output logic [1:0]       flt_code
);

  localparam int SIW = clog2(NS);
  localparam int FW  = AW - MSK;

  state_t          state_q, state_d;
  logic [SIW-1:0]  slot_q, slot_d;
  logic [AW-1:0]   req_adr_q, req_adr_d;
  logic [SW-1:0]   req_sel_q, req_sel_d;
  logic            req_we_q, req_we_d;
  logic [DW-1:0]   req_dat_q, req_dat_d;
  logic [NS-1:0]   stb_q, stb_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic [15:0]     flt_cnt_q, flt_cnt_d;
  logic [AW-1:0]   flt_adr_q, flt_adr_d;
  logic [1:0]      flt_code_q, flt_code_d;

  logic [FW-1:0]   req_field;
  logic [SIW-1:0]  req_slot;
  logic            req_mapped;
  logic            tmr_expired;

  // Slot decode of the incoming master address
  assign req_field  = s_wb_adr[AW-1:MSK];
  assign req_slot   = req_field[SIW-1:0];
  assign req_mapped = (32'(req_field) < 32'(NS));

  wb_fabric_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != ST_ACTIVE),
    .en      (state_q == ST_ACTIVE),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic for the transaction FSM
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    slot_d     = slot_q;
    req_adr_d  = req_adr_q;
    req_sel_d  = req_sel_q;
    req_we_d   = req_we_q;
    req_dat_d  = req_dat_q;
    stb_d      = stb_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdat_d     = '0;
    flt_cnt_d  = flt_cnt_q;
    flt_adr_d  = flt_adr_q;
    flt_code_d = flt_code_q;

    case (state_q)
      ST_IDLE: begin
        if (s_wb_cyc && s_wb_stb) begin
          req_adr_d = s_wb_adr;
          req_sel_d = s_wb_sel;
          req_we_d  = s_wb_we;
          req_dat_d = s_wb_dat_i;
          if (req_mapped) begin
            slot_d           = req_slot;
            stb_d            = '0;
            stb_d[req_slot]  = 1'b1;
            state_d          = ST_ACTIVE;
          end else begin
            err_d      = 1'b1;
            flt_code_d = FLT_UNMAPPED;
            flt_adr_d  = s_wb_adr;
            flt_cnt_d  = sat_inc16(flt_cnt_q);
            state_d    = ST_RESP;
          end
        end
      end

      ST_ACTIVE: begin
        if (!s_wb_cyc) begin
          // Master abandoned the cycle: release the slave silently
          stb_d   = '0;
          state_d = ST_IDLE;
        end else if (m_wb_err[slot_q]) begin
          // err outranks a simultaneous ack
          stb_d      = '0;
          err_d      = 1'b1;
          flt_code_d = FLT_SLV_ERR;
          flt_adr_d  = req_adr_q;
          flt_cnt_d  = sat_inc16(flt_cnt_q);
          state_d    = ST_RESP;
        end else if (m_wb_ack[slot_q]) begin
          stb_d   = '0;
          ack_d   = 1'b1;
          rdat_d  = req_we_q ? '0 : m_wb_dat_i[int'(slot_q)*DW +: DW];
          state_d = ST_RESP;
        end else if (tmr_expired) begin
          stb_d      = '0;
          err_d      = 1'b1;
          flt_code_d = FLT_TIMEOUT;
          flt_adr_d  = req_adr_q;
          flt_cnt_d  = sat_inc16(flt_cnt_q);
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        // Response pulse is on the bus this cycle; master stb is ignored
        state_d = ST_IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      req_adr_q  <= '0;
      req_sel_q  <= '0;
      req_we_q   <= 1'b0;
      req_dat_q  <= '0;
      stb_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
      flt_cnt_q  <= '0;
      flt_adr_q  <= '0;
      flt_code_q <= FLT_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q    <= state_d;
      slot_q     <= slot_d;
      req_adr_q  <= req_adr_d;
      req_sel_q  <= req_sel_d;
      req_we_q   <= req_we_d;
      req_dat_q  <= req_dat_d;
      stb_q      <= stb_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
      flt_cnt_q  <= flt_cnt_d;
      flt_adr_q  <= flt_adr_d;
      flt_code_q <= flt_code_d;
    end
  end

  // Request fields are broadcast; only the selected slot sees cyc/stb
  assign m_wb_adr   = {NS{req_adr_q}};
  assign m_wb_sel   = {NS{req_sel_q}};
  assign m_wb_we    = {NS{req_we_q}};
  assign m_wb_dat_o = {NS{req_dat_q}};
  assign m_wb_cyc   = stb_q;
  assign m_wb_stb   = stb_q;

  assign s_wb_ack   = ack_q;
  assign s_wb_err   = err_q;
  assign s_wb_dat_o = rdat_q;

  assign flt_cnt    = flt_cnt_q;
  assign flt_adr    = flt_adr_q;
  assign flt_code   = flt_code_q;

endmodule

// File: tb/tb_wb_periph_fabric.sv
// Directed bench for wb_periph_fabric: decode, responses, timeout, abort, reset, fault status.
module tb_wb_periph_fabric;

  localparam int NS      = 4;
  localparam int AW      = 32;
  localparam int DW      = 128;
  localparam int MSK     = 24;
  localparam int TIMEOUT = 8;
  localparam int SW      = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    s_wb_adr = '0;
  logic [SW-1:0]    s_wb_sel = '0;
  logic             s_wb_we = 1'b0;
  logic [DW-1:0]    s_wb_dat_i = '0;
  logic [DW-1:0]    s_wb_dat_o;
  logic             s_wb_cyc = 1'b0;
  logic             s_wb_stb = 1'b0;
  logic             s_wb_ack;
  logic             s_wb_err;
  logic [NS*AW-1:0] m_wb_adr;
  logic [NS*SW-1:0] m_wb_sel;
  logic [NS-1:0]    m_wb_we;
  logic [NS*DW-1:0] m_wb_dat_o;
  logic [NS*DW-1:0] m_wb_dat_i = '0;
  logic [NS-1:0]    m_wb_cyc;
  logic [NS-1:0]    m_wb_stb;
  logic [NS-1:0]    m_wb_ack = '0;
  logic [NS-1:0]    m_wb_err = '0;
  logic [15:0]      flt_cnt;
  logic [AW-1:0]    flt_adr;
  logic [1:0]       flt_code;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_periph_fabric #(
    .NS(NS), .AW(AW), .DW(DW), .MSK(MSK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_wb_adr(s_wb_adr), .s_wb_sel(s_wb_sel), .s_wb_we(s_wb_we),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb),
    .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
    .m_wb_adr(m_wb_adr), .m_wb_sel(m_wb_sel), .m_wb_we(m_wb_we),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb),
    .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err),
    .flt_cnt(flt_cnt), .flt_adr(flt_adr), .flt_code(flt_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t reached, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to the n-th following falling edge (drive and sample point)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic [AW-1:0] adr, input logic we,
                     input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    s_wb_adr   = adr;
    s_wb_we    = we;
    s_wb_dat_i = dat;
    s_wb_sel   = sel;
    s_wb_cyc   = 1'b1;
    s_wb_stb   = 1'b1;
  endtask

  task automatic drop();
    s_wb_cyc = 1'b0;
    s_wb_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (m_wb_stb !== 4'b0000) begin n_fail++; $display("FAIL rst_stb: got %b want 0000", m_wb_stb); end
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b00) begin n_fail++; $display("FAIL rst_resp: got %b want 00", {s_wb_ack, s_wb_err}); end
    n_cmp++; if ({flt_cnt, flt_code, flt_adr} !== 50'd0) begin n_fail++; $display("FAIL rst_flt: got %h want 0", {flt_cnt, flt_code, flt_adr}); end
    n_cmp++; if (m_wb_adr !== '0) begin n_fail++; $display("FAIL rst_madr: got %h want 0", m_wb_adr); end
    step(2);
    rst_n = 1'b1;
    step(1);
    n_cmp++; if ({m_wb_cyc, s_wb_ack, s_wb_err} !== 6'd0) begin n_fail++; $display("FAIL rst_release: got %b want 0", {m_wb_cyc, s_wb_ack, s_wb_err}); end
  endtask

  // Read slot 2; slave acks after seeing stb for 3 cycles
  task automatic test_read();
    m_wb_dat_i[0*DW +: DW] = {16{8'h11}};
    m_wb_dat_i[1*DW +: DW] = {16{8'h22}};
    m_wb_dat_i[2*DW +: DW] = {16{8'hA5}};
    m_wb_dat_i[3*DW +: DW] = {16{8'h33}};
    req(32'h0200_0010, 1'b0, '0, 16'hFFFF);
    step(1);
    n_cmp++; if (m_wb_stb !== 4'b0100) begin n_fail++; $display("FAIL rd_stb: got %b want 0100", m_wb_stb); end
    n_cmp++; if (m_wb_cyc !== 4'b0100) begin n_fail++; $display("FAIL rd_cyc: got %b want 0100", m_wb_cyc); end
    n_cmp++; if (m_wb_adr[2*AW +: AW] !== 32'h0200_0010) begin n_fail++; $display("FAIL rd_adr: got %h want 02000010", m_wb_adr[2*AW +: AW]); end
    step(1);
    m_wb_ack = 4'b0010;  // stray ack from a non-selected slot
    step(1);
    m_wb_ack = 4'b0000;
    n_cmp++; if (s_wb_ack !== 1'b0) begin n_fail++; $display("FAIL rd_stray_ack: got %b want 0", s_wb_ack); end
    step(1);
    m_wb_ack = 4'b0100;
    n_cmp++; if (s_wb_ack !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack: got %b want 0", s_wb_ack); end
    step(1);
    m_wb_ack = 4'b0000;
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got %b want 10", {s_wb_ack, s_wb_err}); end
    n_cmp++; if (s_wb_dat_o !== {16{8'hA5}}) begin n_fail++; $display("FAIL rd_dat: got %h want a5..a5", s_wb_dat_o); end
    n_cmp++; if (m_wb_stb !== 4'b0000) begin n_fail++; $display("FAIL rd_stb_drop: got %b want 0000", m_wb_stb); end
    drop();
    step(1);
    n_cmp++; if (s_wb_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse: got %b want 0", s_wb_ack); end
  endtask

  task automatic test_unmapped();
    req(32'h0700_0000, 1'b1, {4{32'h0BAD_0BAD}}, 16'hFFFF);
    step(1);
    drop();
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b01) begin n_fail++; $display("FAIL um_err: got %b want 01", {s_wb_ack, s_wb_err}); end
    n_cmp++; if (m_wb_stb !== 4'b0000) begin n_fail++; $display("FAIL um_stb: got %b want 0000", m_wb_stb); end
    n_cmp++; if (flt_code !== 2'd1) begin n_fail++; $display("FAIL um_code: got %0d want 1", flt_code); end
    n_cmp++; if (flt_adr !== 32'h0700_0000) begin n_fail++; $display("FAIL um_adr: got %h want 07000000", flt_adr); end
    n_cmp++; if (flt_cnt !== 16'd1) begin n_fail++; $display("FAIL um_cnt: got %0d want 1", flt_cnt); end
    step(1);
    n_cmp++; if (s_wb_err !== 1'b0) begin n_fail++; $display("FAIL um_err_pulse: got %b want 0", s_wb_err); end
  endtask

  // Slot 1 never responds; fabric forces err after TIMEOUT cycles
  task automatic test_timeout();
    int hi = 0;
    req(32'h0100_0000, 1'b0, '0, 16'hFFFF);
    for (int k = 0; k < TIMEOUT; k++) begin
      step(1);
      if (m_wb_stb == 4'b0010 && !s_wb_err) hi++;
    end
    n_cmp++; if (hi !== TIMEOUT) begin n_fail++; $display("FAIL to_stb_cycles: got %0d want %0d", hi, TIMEOUT); end
    step(1);
    drop();
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b01) begin n_fail++; $display("FAIL to_err: got %b want 01", {s_wb_ack, s_wb_err}); end
    n_cmp++; if (m_wb_stb !== 4'b0000) begin n_fail++; $display("FAIL to_stb_drop: got %b want 0000", m_wb_stb); end
    n_cmp++; if (flt_code !== 2'd2) begin n_fail++; $display("FAIL to_code: got %0d want 2", flt_code); end
    n_cmp++; if (flt_cnt !== 16'd2) begin n_fail++; $display("FAIL to_cnt: got %0d want 2", flt_cnt); end
    n_cmp++; if (flt_adr !== 32'h0100_0000) begin n_fail++; $display("FAIL to_adr: got %h want 01000000", flt_adr); end
    step(1);
  endtask

  // Slot 0 acks and errs together; then a stray ack on slot 3 while idle
  task automatic test_ack_err();
    req(32'h0000_0040, 1'b1, {4{32'hDEAD_BEEF}}, 16'h00FF);
    step(1);
    n_cmp++; if (m_wb_stb !== 4'b0001) begin n_fail++; $display("FAIL ae_stb: got %b want 0001", m_wb_stb); end
    n_cmp++; if (m_wb_we !== 4'b1111) begin n_fail++; $display("FAIL ae_we: got %b want 1111", m_wb_we); end
    n_cmp++; if (m_wb_dat_o[0 +: DW] !== {4{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL ae_wdat: got %h want deadbeef x4", m_wb_dat_o[0 +: DW]); end
    n_cmp++; if (m_wb_sel[0 +: SW] !== 16'h00FF) begin n_fail++; $display("FAIL ae_sel: got %h want 00ff", m_wb_sel[0 +: SW]); end
    n_cmp++; if (m_wb_adr[3*AW +: AW] !== 32'h0000_0040) begin n_fail++; $display("FAIL ae_bcast_adr: got %h want 00000040", m_wb_adr[3*AW +: AW]); end
    m_wb_ack = 4'b0001;
    m_wb_err = 4'b0001;
    step(1);
    m_wb_ack = 4'b0000;
    m_wb_err = 4'b0000;
    drop();
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b01) begin n_fail++; $display("FAIL ae_resp: got %b want 01", {s_wb_ack, s_wb_err}); end
    n_cmp++; if (flt_code !== 2'd3) begin n_fail++; $display("FAIL ae_code: got %0d want 3", flt_code); end
    n_cmp++; if (flt_cnt !== 16'd3) begin n_fail++; $display("FAIL ae_cnt: got %0d want 3", flt_cnt); end
    n_cmp++; if (flt_adr !== 32'h0000_0040) begin n_fail++; $display("FAIL ae_adr: got %h want 00000040", flt_adr); end
    step(1);
    m_wb_ack = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      step(1);
      n_cmp++; if ({s_wb_ack, s_wb_err, m_wb_stb} !== 6'd0) begin n_fail++; $display("FAIL idle_stray_ack: got %b want 0", {s_wb_ack, s_wb_err, m_wb_stb}); end
    end
    m_wb_ack = 4'b0000;
  endtask

  // Master abandons a slot 3 cycle; the next read on slot 2 completes
  task automatic test_abort();
    req(32'h0300_0100, 1'b0, '0, 16'hFFFF);
    step(1);
    n_cmp++; if (m_wb_stb !== 4'b1000) begin n_fail++; $display("FAIL ab_stb: got %b want 1000", m_wb_stb); end
    step(2);
    drop();
    step(1);
    n_cmp++; if ({m_wb_cyc, m_wb_stb} !== 8'd0) begin n_fail++; $display("FAIL ab_release: got %b want 0", {m_wb_cyc, m_wb_stb}); end
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b00) begin n_fail++; $display("FAIL ab_resp: got %b want 00", {s_wb_ack, s_wb_err}); end
    step(1);
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b00) begin n_fail++; $display("FAIL ab_resp_late: got %b want 00", {s_wb_ack, s_wb_err}); end
    n_cmp++; if (flt_cnt !== 16'd3) begin n_fail++; $display("FAIL ab_cnt: got %0d want 3", flt_cnt); end
    m_wb_dat_i[2*DW +: DW] = {4{32'h1234_5678}};
    req(32'h0200_0000, 1'b0, '0, 16'hFFFF);
    step(1);
    n_cmp++; if (m_wb_stb !== 4'b0100) begin n_fail++; $display("FAIL ab_next_stb: got %b want 0100", m_wb_stb); end
    m_wb_ack = 4'b0100;
    step(1);
    m_wb_ack = 4'b0000;
    drop();
    n_cmp++; if (s_wb_ack !== 1'b1) begin n_fail++; $display("FAIL ab_next_ack: got %b want 1", s_wb_ack); end
    n_cmp++; if (s_wb_dat_o !== {4{32'h1234_5678}}) begin n_fail++; $display("FAIL ab_next_dat: got %h want 12345678 x4", s_wb_dat_o); end
    step(1);
  endtask

  // Acked write to slot 1 returns zero data
  task automatic test_write_ack();
    req(32'h0100_0008, 1'b1, {4{32'hCAFE_F00D}}, 16'hF0F0);
    step(1);
    n_cmp++; if (m_wb_dat_o[1*DW +: DW] !== {4{32'hCAFE_F00D}}) begin n_fail++; $display("FAIL wr_wdat: got %h want cafef00d x4", m_wb_dat_o[1*DW +: DW]); end
    n_cmp++; if (m_wb_sel[1*SW +: SW] !== 16'hF0F0) begin n_fail++; $display("FAIL wr_sel: got %h want f0f0", m_wb_sel[1*SW +: SW]); end
    m_wb_ack = 4'b0010;
    step(1);
    m_wb_ack = 4'b0000;
    drop();
    n_cmp++; if ({s_wb_ack, s_wb_err} !== 2'b10) begin n_fail++; $display("FAIL wr_ack: got %b want 10", {s_wb_ack, s_wb_err}); end
    n_cmp++; if (s_wb_dat_o !== '0) begin n_fail++; $display("FAIL wr_rdat: got %h want 0", s_wb_dat_o); end
    step(1);
  endtask

  // Asynchronous reset in the middle of an active slave cycle
  task automatic test_reset_mid();
    req(32'h0200_0000, 1'b0, '0, 16'hFFFF);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({m_wb_cyc, m_wb_stb} !== 8'd0) begin n_fail++; $display("FAIL rm_stb: got %b want 0", {m_wb_cyc, m_wb_stb}); end
    n_cmp++; if (m_wb_adr !== '0) begin n_fail++; $display("FAIL rm_madr: got %h want 0", m_wb_adr); end
    n_cmp++; if (flt_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", flt_cnt); end
    n_cmp++; if ({flt_code, flt_adr} !== 34'd0) begin n_fail++; $display("FAIL rm_flt: got %h want 0", {flt_code, flt_adr}); end
    drop();
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  // Fault counter saturation at 16'hFFFF
  task automatic test_saturation();
    logic [15:0] exp_cnt [4];
    exp_cnt[0] = 16'h0001;
    exp_cnt[1] = 16'hFFFE;
    exp_cnt[2] = 16'hFFFF;
    exp_cnt[3] = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        force dut.flt_cnt_q = 16'hFFFD;
        step(1);
        release dut.flt_cnt_q;
      end
      req(32'h0500_0000 + 32'(k), 1'b0, '0, 16'hFFFF);
      step(1);
      drop();
      n_cmp++; if (s_wb_err !== 1'b1) begin n_fail++; $display("FAIL sat_err[%0d]: got %b want 1", k, s_wb_err); end
      n_cmp++; if (flt_cnt !== exp_cnt[k]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %h want %h", k, flt_cnt, exp_cnt[k]); end
      step(1);
    end
    n_cmp++; if (flt_adr !== 32'h0500_0003) begin n_fail++; $display("FAIL sat_adr: got %h want 05000003", flt_adr); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_unmapped();
    test_timeout();
    test_ack_err();
    test_abort();
    test_write_ack();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
